// File: rtl/mouse_packet_decoder_if.sv
// Byte-receiver to mouse-register bundle around the PS/2 packet decoder.
// The master is the receiver/bus side; the slave is the decoder.
interface mouse_packet_decoder_if #(
    parameter int POS_W = 8
);
    logic             enable;
    logic [7:0]       byte_read;
    logic [1:0]       byte_error_code;
    logic             byte_ready;
    logic             read_enable;
    logic             packet_valid;
    logic [7:0]       mouse_status;
    logic [8:0]       mouse_dx;
    logic [8:0]       mouse_dy;
    logic [POS_W-1:0] mouse_x;
    logic [POS_W-1:0] mouse_y;
    logic [7:0]       err_count;

    modport master (
        output enable, byte_read, byte_error_code, byte_ready,
        input  read_enable, packet_valid, mouse_status, mouse_dx, mouse_dy,
               mouse_x, mouse_y, err_count
    );

    modport slave (
        input  enable, byte_read, byte_error_code, byte_ready,
        output read_enable, packet_valid, mouse_status, mouse_dx, mouse_dy,
               mouse_x, mouse_y, err_count
    );
endinterface

// File: rtl/mouse_packet_decoder.sv
// Frames PS/2 stream-mode bytes into 3-byte packets, checks sync/errors/gaps,
// and integrates the deltas into clamped absolute X/Y positions.
module mouse_packet_decoder #(
    parameter int X_MAX       = 160,
    parameter int Y_MAX       = 120,
    parameter int POS_W       = 8,
    parameter int GAP_TIMEOUT = 1000000
) (
    input  logic clk_i,
    input  logic reset_i,
    mouse_packet_decoder_if.slave bus
);
    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
    localparam int SUM_W = POS_W + 2;
    localparam logic [GAP_W-1:0]        GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic signed [SUM_W-1:0] X_HI     = SUM_W'(X_MAX - 1);
    localparam logic signed [SUM_W-1:0] Y_HI     = SUM_W'(Y_MAX - 1);
    localparam logic [POS_W-1:0]        X_MID    = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0]        Y_MID    = POS_W'(Y_MAX / 2);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       stat_pend_q, stat_pend_d;
    logic [7:0]       dx_lo_q, dx_lo_d;
    logic             err_inc, apply, byte_good;

    logic signed [8:0]       dx_pkt, dy_pkt;
    logic signed [SUM_W-1:0] x_sum, y_sum;
    logic [POS_W-1:0]        x_new, y_new;

    logic                    read_enable_q, packet_valid_q;
    logic [7:0]              status_q, err_q;
    logic signed [8:0]       dx_q, dy_q;
    logic [POS_W-1:0]        x_q, y_q;

    assign byte_good = (bus.byte_error_code == 2'b00);

    always_comb begin : fsm_next
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        state_d     = state_q;
        gap_d       = gap_q;
        stat_pend_d = stat_pend_q;
        dx_lo_d     = dx_lo_q;
        err_inc     = 1'b0;
        apply       = 1'b0;
        if (!bus.enable) begin
            state_d = WAIT_B0;
            gap_d   = '0;
        end else if (bus.byte_ready) begin
            // A byte on the timeout cycle lands here, so it beats the timeout.
            gap_d = '0;
            unique case (state_q)
                WAIT_B0: begin
                    if (byte_good && bus.byte_read[3]) begin
                        state_d     = WAIT_B1;
                        stat_pend_d = bus.byte_read;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                WAIT_B1: begin
                    if (byte_good) begin
                        state_d = WAIT_B2;
                        dx_lo_d = bus.byte_read;
                    end else begin
                        state_d = WAIT_B0;
                        err_inc = 1'b1;
                    end
                end
                WAIT_B2: begin
                    state_d = WAIT_B0;
                    if (byte_good) apply   = 1'b1;
                    else           err_inc = 1'b1;
                end
                default: state_d = WAIT_B0;
            endcase
        end else if (state_q != WAIT_B0) begin
            if (gap_q == GAP_LAST) begin
                state_d = WAIT_B0;
                gap_d   = '0;
                err_inc = 1'b1;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
    end

    always_comb begin : position_math
        dx_pkt = stat_pend_q[6] ? 9'sd0 : {stat_pend_q[4], dx_lo_q};
        dy_pkt = stat_pend_q[7] ? 9'sd0 : {stat_pend_q[5], bus.byte_read};
        x_sum  = $signed({2'b00, x_q}) + SUM_W'(dx_pkt);
        y_sum  = $signed({2'b00, y_q}) - SUM_W'(dy_pkt);
        // Screen Y grows downward while mouse +Y is up, hence the subtraction.
        if (x_sum[SUM_W-1])   x_new = '0;
        else if (x_sum > X_HI) x_new = X_HI[POS_W-1:0];
        else                   x_new = x_sum[POS_W-1:0];
        if (y_sum[SUM_W-1])   y_new = '0;
        else if (y_sum > Y_HI) y_new = Y_HI[POS_W-1:0];
        else                   y_new = y_sum[POS_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= WAIT_B0;
            gap_q          <= '0;
            stat_pend_q    <= '0;
            dx_lo_q        <= '0;
            read_enable_q  <= 1'b0;
            packet_valid_q <= 1'b0;
            status_q       <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            x_q            <= X_MID;
            y_q            <= Y_MID;
            err_q          <= '0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            stat_pend_q    <= stat_pend_d;
            dx_lo_q        <= dx_lo_d;
            read_enable_q  <= bus.enable;
            packet_valid_q <= apply;
            if (apply) begin
                status_q <= stat_pend_q;
                dx_q     <= dx_pkt;
                dy_q     <= dy_pkt;
                x_q      <= x_new;
                y_q      <= y_new;
            end
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    assign bus.read_enable  = read_enable_q;
    assign bus.packet_valid = packet_valid_q;
    assign bus.mouse_status = status_q;
    assign bus.mouse_dx     = dx_q;
    assign bus.mouse_dy     = dy_q;
    assign bus.mouse_x      = x_q;
    assign bus.mouse_y      = y_q;
    assign bus.err_count    = err_q;
endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Randomized and directed bench for mouse_packet_decoder against a
// packet-queue reference model.
module tb_mouse_packet_decoder;
    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;
    localparam int POS_W = 8;
    localparam int GAP   = 40;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mouse_packet_decoder_if #(.POS_W(POS_W)) bus ();

    mouse_packet_decoder #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .POS_W(POS_W), .GAP_TIMEOUT(GAP)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bytes of the packet being collected plus plain integers.
    logic [7:0] pkt[$];
    int mx, my, merr, mstat, mdx, mdy, mpv, mre, idle_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sx9(input logic s, input logic [7:0] b);
        return s ? int'(b) - 256 : int'(b);
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic bump_err();
        if (merr < 255) merr++;
    endtask

    task automatic apply_pkt();
        logic [7:0] s;
        s     = pkt[0];
        mdx   = s[6] ? 0 : sx9(s[4], pkt[1]);
        mdy   = s[7] ? 0 : sx9(s[5], pkt[2]);
        mx    = clampi(mx + mdx, X_MAX - 1);
        my    = clampi(my - mdy, Y_MAX - 1);
        mstat = int'(s);
        mpv   = 1;
        pkt.delete();
    endtask

    task automatic model_edge(input logic rdy, input logic [7:0] b, input logic [1:0] code);
        mpv = 0;
        if (rst) begin
            mx = X_MAX / 2; my = Y_MAX / 2; merr = 0;
            mstat = 0; mdx = 0; mdy = 0; mre = 0; idle_cnt = 0;
            pkt.delete();
            return;
        end
        mre = int'(bus.enable);
        if (!bus.enable) begin
            pkt.delete();
            idle_cnt = 0;
        end else if (rdy) begin
            idle_cnt = 0;
            if (code != 2'b00) begin
                bump_err();
                pkt.delete();
            end else if (pkt.size() == 0 && !b[3]) begin
                bump_err();
            end else begin
                pkt.push_back(b);
                if (pkt.size() == 3) apply_pkt();
            end
        end else if (pkt.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == GAP) begin
                pkt.delete();
                idle_cnt = 0;
                bump_err();
            end
        end
    endtask

    // One clock: drive, let the edge happen, update model, compare at the falling edge.
    task automatic step(input logic rdy, input logic [7:0] b, input logic [1:0] code);
        bus.byte_ready      = rdy;
        bus.byte_read       = b;
        bus.byte_error_code = code;
        @(posedge clk);
        model_edge(rdy, b, code);
        @(negedge clk);
        bus.byte_ready = 1'b0;
        check("packet_valid", int'(bus.packet_valid), mpv);
        check("status", int'(bus.mouse_status), mstat);
        check("dx", int'($signed(bus.mouse_dx)), mdx);
        check("dy", int'($signed(bus.mouse_dy)), mdy);
        check("x", int'(bus.mouse_x), mx);
        check("y", int'(bus.mouse_y), my);
        check("err_count", int'(bus.err_count), merr);
        check("read_enable", int'(bus.read_enable), mre);
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] code = 2'b00);
        step(1'b1, b, code);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 2'b00);
        rst = 1'b0;
    endtask

    logic [7:0] rb;
    logic [1:0] rc;
    logic       rr;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.enable          = 1'b1;
        bus.byte_ready      = 1'b0;
        bus.byte_read       = 8'h00;
        bus.byte_error_code = 2'b00;
        pkt.delete();

        // Reset state and basic packet
        do_reset();
        check("rst_x", int'(bus.mouse_x), 80);
        check("rst_y", int'(bus.mouse_y), 60);
        check("rst_read_enable", int'(bus.read_enable), 0);
        send(8'h08); idle(2); send(8'h05); send(8'h03);
        check("t1_pv", int'(bus.packet_valid), 1);
        check("t1_dx", int'($signed(bus.mouse_dx)), 5);
        check("t1_dy", int'($signed(bus.mouse_dy)), 3);
        check("t1_x", int'(bus.mouse_x), 85);
        check("t1_y", int'(bus.mouse_y), 57);
        idle(1);
        check("t1_pv_pulse", int'(bus.packet_valid), 0);

        // Negative deltas via sign bits
        do_reset();
        send(8'h38); send(8'hFB); send(8'hFE);
        check("t2_x", int'(bus.mouse_x), 75);
        check("t2_y", int'(bus.mouse_y), 62);

        // Clamping at both X limits
        do_reset();
        for (int i = 0; i < 18; i++) begin send(8'h08); send(8'h7F); send(8'h00); end
        check("t3_x_max", int'(bus.mouse_x), 159);
        for (int i = 0; i < 18; i++) begin send(8'h18); send(8'h80); send(8'h00); end
        check("t3_x_min", int'(bus.mouse_x), 0);

        // Sync bit
        do_reset();
        send(8'h00); send(8'h08); send(8'h01); send(8'h02);
        check("t4_err", int'(bus.err_count), 1);
        check("t4_dx", int'($signed(bus.mouse_dx)), 1);
        check("t4_dy", int'($signed(bus.mouse_dy)), 2);

        // Byte error mid-packet, X overflow
        do_reset();
        send(8'h08); send(8'h05, 2'b01);
        check("t5_err", int'(bus.err_count), 1);
        check("t5_no_pv", int'(bus.packet_valid), 0);
        send(8'h48); send(8'h05); send(8'h01);
        check("t5_ovf_dx", int'($signed(bus.mouse_dx)), 0);
        check("t5_ovf_x", int'(bus.mouse_x), 80);

        // Gap timeout and the byte-on-timeout-cycle edge
        do_reset();
        send(8'h08); idle(GAP);
        check("t6_timeout_err", int'(bus.err_count), 1);
        send(8'h08); send(8'h01); send(8'h01);
        check("t6_after_x", int'(bus.mouse_x), 81);
        send(8'h08); idle(GAP - 1); send(8'h01); send(8'h02);
        check("t6_edge_pv", int'(bus.packet_valid), 1);
        check("t6_edge_err", int'(bus.err_count), 1);
        check("t6_edge_x", int'(bus.mouse_x), 82);

        // Reset mid-packet
        send(8'h08); send(8'h05);
        do_reset();
        check("t6_rst_x", int'(bus.mouse_x), 80);
        check("t6_rst_y", int'(bus.mouse_y), 60);
        send(8'h08); send(8'h02); send(8'h02);
        check("t6_rst_pkt_x", int'(bus.mouse_x), 82);

        // ENABLE low drops partial packet silently
        send(8'h08); send(8'h05);
        bus.enable = 1'b0; step(1'b1, 8'h09, 2'b00);
        bus.enable = 1'b1;
        send(8'h08); send(8'h01); send(8'h01);
        check("en_drop_err", int'(bus.err_count), 0);
        check("en_drop_x", int'(bus.mouse_x), 83);

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) send(8'h00);
        check("err_sat", int'(bus.err_count), 255);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.enable = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 199) == 0) begin
                bus.enable = 1'b1;
                idle(GAP + 3);
            end
            rr = ($urandom_range(0, 1) == 1);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) != 0) rb[3] = 1'b1;
            rc = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(rr, rb, rc);
        end
        bus.enable = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
